fc_argmax_stage: RTL and testbench



---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_argmax_stage_counter.sv | 43 ++++
 rtl/fc_argmax_stage.sv | 134 +++++++++++++
 tb/tb_fc_argmax_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: definitions shared by the FC layer generator and the argmax stage.
//   argmax_state_t : argmax FSM state encoding (ACCUM collects, EMIT presents)
//   M_DEF / T_DEF  : default vector length and element width
//   iw_of()        : index width for an M-element vector, never below 1 bit
package fc_pkg;

    localparam int M_DEF = 16;
    localparam int T_DEF = 16;

    typedef enum logic [0:0] {ACCUM, EMIT} argmax_state_t;

    // $clog2(1) and $clog2(2) would give 0 and 1. Clamping to 1 keeps every
    // index bus at least one bit wide.
    function automatic int iw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_argmax_stage_counter.sv
// fc_argmax_stage_counter: wrapping up-counter 0..OF-1.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   clr_i       : synchronous clear, takes priority over inc_i
//   inc_i       : advance by one
//   count_o     : current count
//   overflow_o  : inc_i at OF-1 with no clear, i.e. the counter wrapped by itself
module fc_argmax_stage_counter #(
    parameter int OF = 16,
    parameter int W  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         overflow_o
);

    logic [W-1:0] count_q, count_d;
    logic         at_top;

    assign at_top = (count_q == W'(OF - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i)
            count_d = at_top ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o    = count_q;
    assign overflow_o = inc_i && !clr_i && at_top;

endmodule

// File: rtl/fc_argmax_stage.sv
// fc_argmax_stage: streaming argmax over M signed T-bit elements per vector,
// sitting between the FC layer output and the result sink.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   input_valid/input_ready/input_data: element stream from the FC layer
//   output_valid/output_ready         : result handshake
//   output_index                      : index of the maximum (lowest on ties)
//   output_max                        : value of the maximum
// Build option FC_ARGMAX_OVERLAP_EN: while a result is presented, the first
// element of the next vector may be accepted in the same cycle as the result
// handshake (input_ready follows output_ready in EMIT), giving M cycles per
// vector instead of M+1.
module fc_argmax_stage
    import fc_pkg::*;
#(
    parameter  int M  = M_DEF,
    parameter  int T  = T_DEF,
    localparam int IW = iw_of(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic [T-1:0]  input_data,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [IW-1:0] output_index,
    output logic [T-1:0]  output_max
);

    argmax_state_t state_q, state_d;

    logic [T-1:0]  max_q,     max_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [T-1:0]  out_max_q, out_max_d;
    logic [IW-1:0] out_idx_q, out_idx_d;

    logic [IW-1:0] cnt;
    logic          cnt_ovf;
    logic          rdy;
    logic          accept;
    logic          last;
    logic          take;
    logic [T-1:0]  cand_max;
    logic [IW-1:0] cand_idx;

    // In EMIT the counter is always 0 (cleared on the final accept), so an
    // overlapped accept there is naturally element k=0 of the next vector.
    always_comb begin
        rdy = (state_q == ACCUM);
`ifdef FC_ARGMAX_OVERLAP_EN
        if (state_q == EMIT)
            rdy = output_ready;
`endif
    end

    assign input_ready = rdy && !reset;
    assign accept      = input_valid && input_ready;
    assign last        = (cnt == IW'(M - 1));

    // First element seeds unconditionally; later ones only on strictly
    // greater, so ties keep the lowest index.
    assign take     = (cnt == '0) || ($signed(input_data) > $signed(max_q));
    assign cand_max = take ? input_data : max_q;
    assign cand_idx = take ? cnt : idx_q;

    fc_argmax_stage_counter #(
        .OF (M),
        .W  (IW)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (accept && last),
        .inc_i      (accept),
        .count_o    (cnt),
        .overflow_o (cnt_ovf)
    );

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        idx_d     = idx_q;
        out_max_d = out_max_q;
        out_idx_d = out_idx_q;

        if (accept) begin
            max_d = cand_max;
            idx_d = cand_idx;
        end

        case (state_q)
            ACCUM: begin
                if (accept && last) begin
                    out_max_d = cand_max;
                    out_idx_d = cand_idx;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (output_ready)
                    state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACCUM;
            max_q     <= '0;
            idx_q     <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
        end
    end

    // The wrap at M-1 is done by the explicit clear, so the counter's own
    // wrap must never fire.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!cnt_ovf);
    end

    assign output_valid = (state_q == EMIT);
    assign output_index = out_idx_q;
    assign output_max   = out_max_q;

endmodule

// File: tb/tb_fc_argmax_stage.sv
module tb_fc_argmax_stage;

    localparam int M  = 16;
    localparam int T  = 16;
    localparam int IW = 4;

    typedef logic [M-1:0][T-1:0] vec_data_t;

    typedef struct {
        string     name;
        vec_data_t v;
        int        gap;
        int        idx;
        logic [T-1:0] mx;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          input_valid = 1'b0;
    logic [T-1:0]  input_data = '0;
    logic          output_ready = 1'b1;
    logic          input_ready;
    logic          output_valid;
    logic [IW-1:0] output_index;
    logic [T-1:0]  output_max;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nres  = 0;

    vec_t tbl[7];

    int ov_got;
    int ov_ix[3];
    int ov_cy[3];

    fc_argmax_stage #(.M(M), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_index (output_index),
        .output_max   (output_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && output_valid && output_ready)
            nres <= nres + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one element and hold it until accepted (bounded wait).
    task automatic send_elem(input logic [T-1:0] d);
        int w;
        w = 0;
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = d;
        #1;
        while (!input_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!input_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: input_ready stuck at 0 after %0d cycles", w);
        end
        @(posedge clk);
        #1;
        input_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_data_t v, input int gap);
        for (int k = 0; k < M; k++) begin
            send_elem(v[k]);
            repeat (gap) @(negedge clk);
        end
    endtask

    // Called just after the edge that accepted the last element.
    task automatic check_result(input string name, input int idx, input logic [T-1:0] mx);
        chk({name, "_valid"}, {31'd0, output_valid}, 32'd1);
        chk({name, "_index"}, {28'd0, output_index}, idx);
        chk({name, "_max"},   {16'd0, output_max},   {16'd0, mx});
        chk({name, "_ready_in_emit"}, {31'd0, input_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_pulse"}, {31'd0, output_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        input_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vec_data_t v;
        int r0;

        for (int i = 0; i < 7; i++) begin
            tbl[i].v = '0;
            tbl[i].gap = i % 2;
        end
        tbl[0].name = "ascending";
        for (int k = 0; k < M; k++) tbl[0].v[k] = T'(k);
        tbl[0].idx = 15; tbl[0].mx = 16'd15;

        tbl[1].name = "dup_max";
        tbl[1].v[3] = 16'd5; tbl[1].v[9] = 16'd5;
        tbl[1].idx = 3; tbl[1].mx = 16'd5;

        tbl[2].name = "all_neg";
        for (int k = 3; k < M; k++) tbl[2].v[k] = T'(-(200 + k));
        tbl[2].v[0] = T'(-100); tbl[2].v[1] = T'(-3); tbl[2].v[2] = T'(-50);
        tbl[2].idx = 1; tbl[2].mx = 16'hFFFD;

        tbl[3].name = "all_min";
        for (int k = 0; k < M; k++) tbl[3].v[k] = 16'h8000;
        tbl[3].idx = 0; tbl[3].mx = 16'h8000;

        tbl[4].name = "all_zero";
        tbl[4].idx = 0; tbl[4].mx = 16'h0000;

        tbl[5].name = "extreme";
        for (int k = 0; k < M; k++) tbl[5].v[k] = T'(k * 3);
        tbl[5].v[0] = 16'h8000; tbl[5].v[7] = 16'h7FFF; tbl[5].v[15] = 16'h7FFE;
        tbl[5].idx = 7; tbl[5].mx = 16'h7FFF;

        tbl[6].name = "mixed_sign";
        for (int k = 0; k < M; k++) tbl[6].v[k] = T'((k - 8) * 1000);
        tbl[6].v[10] = T'(9000);
        tbl[6].idx = 10; tbl[6].mx = 16'd9000;

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_output_valid", {31'd0, output_valid}, 32'd0);
        chk("rst_output_index", {28'd0, output_index}, 32'd0);
        chk("rst_output_max",   {16'd0, output_max},   32'd0);
        chk("rst_input_ready",  {31'd0, input_ready},  32'd1);

        // Table-driven vectors, output_ready held high.
        for (int i = 0; i < 7; i++) begin
            send_vec(tbl[i].v, tbl[i].gap);
            check_result(tbl[i].name, tbl[i].idx, tbl[i].mx);
        end

        // Backpressure: result held, next vector's first element waits upstream.
        output_ready = 1'b0;
        send_vec(tbl[1].v, 0);
        @(negedge clk);
        input_valid = 1'b1;
        input_data  = 16'd100;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_valid", {31'd0, output_valid}, 32'd1);
            chk("bp_index", {28'd0, output_index}, 32'd3);
            chk("bp_max",   {16'd0, output_max},   32'd5);
            chk("bp_ready", {31'd0, input_ready},  32'd0);
            @(negedge clk);
        end
        output_ready = 1'b1;
        v = '0;
        v[0] = 16'd100;
        for (int k = 1; k < M; k++) v[k] = T'(k);
        send_vec(v, 0);
        check_result("bp_next", 0, 16'd100);

        // Reset after 7 accepts: partial vector discarded.
        r0 = nres;
        send_elem(16'd1000);
        for (int k = 1; k < 7; k++) send_elem(T'(k));
        do_reset();
        chk("midrst_valid", {31'd0, output_valid}, 32'd0);
        for (int k = 0; k < M; k++) v[k] = T'(k);
        v[12] = 16'd42;
        send_vec(v, 0);
        check_result("midrst", 12, 16'd42);
        chk("midrst_nres", nres, r0 + 1);

        // Reset while a result is pending: result dropped.
        output_ready = 1'b0;
        send_vec(tbl[0].v, 0);
        #1;
        chk("emitrst_pending", {31'd0, output_valid}, 32'd1);
        r0 = nres;
        do_reset();
        output_ready = 1'b1;
        chk("emitrst_valid", {31'd0, output_valid}, 32'd0);
        chk("emitrst_max",   {16'd0, output_max},   32'd0);
        repeat (3) @(negedge clk);
        chk("emitrst_nres", nres, r0);

`ifdef FC_ARGMAX_OVERLAP_EN
        // Back-to-back vectors with continuous valid: one result every M cycles.
        ov_got = 0;
        fork
            begin
                vec_data_t a, b;
                a = '0; b = '0;
                for (int k = 0; k < M; k++) begin a[k] = T'(k); b[k] = T'(k); end
                a[2] = 16'd50;
                b[14] = 16'd60;
                send_vec(a, 0);
                send_vec(b, 0);
                send_vec(a, 0);
            end
            begin
                int w;
                w = 0;
                while (ov_got < 3 && w < 300) begin
                    @(negedge clk);
                    w++;
                    if (output_valid && output_ready) begin
                        ov_ix[ov_got] = int'(output_index);
                        ov_cy[ov_got] = cyc;
                        ov_got++;
                    end
                end
            end
        join
        chk("ov_count", ov_got, 3);
        if (ov_got == 3) begin
            chk("ov_idx0", ov_ix[0], 2);
            chk("ov_idx1", ov_ix[1], 14);
            chk("ov_idx2", ov_ix[2], 2);
            chk("ov_gap01", ov_cy[1] - ov_cy[0], M);
            chk("ov_gap12", ov_cy[2] - ov_cy[1], M);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
